// File: rtl/csa_pkg.sv
// csa_pkg: level/stage sizing helpers and the sum/carry pair type
// shared by the carry-save reduction tree.
package csa_pkg;

  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int csa_width_after(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) begin
      if (m > 2) m = csa_next(m);
    end
    return m;
  endfunction

  function automatic int csa_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = csa_next(m);
      l++;
    end
    return l;
  endfunction

  function automatic int csa_stages(input int n, input int r);
    return (csa_levels(n) + r - 1) / r;
  endfunction

  localparam int CSA_DEF_LEVELS = csa_levels(8);
  localparam int CSA_DEF_STAGES = csa_stages(8, 2);

endpackage

`ifndef CSA_PAIR_T
`define CSA_PAIR_T(W) struct packed { logic [(W)-1:0] sum; logic [(W)-1:0] carry; }
`endif

// File: rtl/csa3_2_row.sv
// csa3_2_row: one WIDTH-bit 3:2 compressor row; the carry is
// pre-shifted into sum alignment with its top bit dropped.
module csa3_2_row
  import csa_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | ((a ^ b) & c);
  assign carry = maj << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined Wallace-style 3:2 reduction of NUM_IN operands.
// CSA_TREE_FINAL_ADD_EN adds a registered final adder stage and io_out_res.
module csa_tree_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH     = 13,
  parameter int NUM_IN    = 8,
  parameter int REG_EVERY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_flush,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [NUM_IN*WIDTH-1:0] io_in_bits,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [WIDTH-1:0]        io_out_sum,
`ifdef CSA_TREE_FINAL_ADD_EN
  output logic [WIDTH-1:0]        io_out_carry,
  output logic [WIDTH-1:0]        io_out_res
`else
  output logic [WIDTH-1:0]        io_out_carry
`endif
);

  localparam int L = csa_levels(NUM_IN);
  localparam int S = csa_stages(NUM_IN, REG_EVERY);
`ifdef CSA_TREE_FINAL_ADD_EN
  localparam int ST = S + 1;
`else
  localparam int ST = S;
`endif

  typedef `CSA_PAIR_T(WIDTH) csa_pair_t;

  logic [ST-1:0] vld;
  logic [ST-1:0] adv;
  logic          chain;
  logic          accept;
  csa_pair_t     tree_out;

  // Advance ripples back from the consumer; never depends on io_in_*.
  always_comb begin
    adv   = '0;
    chain = io_out_ready;
    for (int i = ST - 1; i >= 0; i--) begin
      adv[i] = !vld[i] || chain;
      chain  = adv[i];
    end
  end

  assign io_in_ready = adv[0] && !io_flush;
  assign accept      = io_in_valid && io_in_ready;

  for (genvar j = 0; j < L; j++) begin : lvl
    localparam int N  = csa_width_after(NUM_IN, j);
    localparam int NO = csa_width_after(NUM_IN, j + 1);
    localparam int T  = N / 3;
    localparam int RM = N % 3;

    logic [N*WIDTH-1:0]  vin;
    logic [NO*WIDTH-1:0] v;

    if (j == 0) begin : g_src
      assign vin = io_in_bits;
    end else if (j % REG_EVERY == 0) begin : g_src
      assign vin = stg[j/REG_EVERY-1].q;
    end else begin : g_src
      assign vin = lvl[j-1].v;
    end

    for (genvar k = 0; k < T; k++) begin : row
      csa3_2_row #(
        .WIDTH(WIDTH)
      ) u_row (
        .a    (vin[(3*k)*WIDTH +: WIDTH]),
        .b    (vin[(3*k+1)*WIDTH +: WIDTH]),
        .c    (vin[(3*k+2)*WIDTH +: WIDTH]),
        .sum  (v[(2*k)*WIDTH +: WIDTH]),
        .carry(v[(2*k+1)*WIDTH +: WIDTH])
      );
    end

    if (RM > 0) begin : g_pass
      assign v[2*T*WIDTH +: RM*WIDTH] = vin[3*T*WIDTH +: RM*WIDTH];
    end
  end

  for (genvar s = 0; s < S; s++) begin : stg
    localparam int HI = ((s + 1) * REG_EVERY < L) ? (s + 1) * REG_EVERY : L;
    localparam int NQ = csa_width_after(NUM_IN, HI);

    logic [NQ*WIDTH-1:0] q;
    logic                v;
    logic                fv;
    logic                cap;

    if (s == 0) begin : g_fv
      assign fv = accept;
    end else begin : g_fv
      assign fv = vld[s-1];
    end

    assign cap    = adv[s] && fv && !io_flush;
    assign vld[s] = v;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v <= 1'b0;
        q <= '0;
      end else begin
        if (io_flush) v <= 1'b0;
        else if (adv[s]) v <= fv;
        if (cap) q <= lvl[HI-1].v;
      end
    end
  end

  // The last tree level always leaves the sum in slot 0, carry in slot 1.
  assign tree_out = {stg[S-1].q[0 +: WIDTH], stg[S-1].q[WIDTH +: WIDTH]};

`ifdef CSA_TREE_FINAL_ADD_EN
  logic             fa_v;
  csa_pair_t        fa_q;
  logic [WIDTH-1:0] fa_res;

  assign vld[S] = fa_v;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fa_v   <= 1'b0;
      fa_q   <= '0;
      fa_res <= '0;
    end else begin
      if (io_flush) fa_v <= 1'b0;
      else if (adv[S]) fa_v <= vld[S-1];
      if (adv[S] && vld[S-1] && !io_flush) begin
        fa_q   <= tree_out;
        fa_res <= tree_out.sum + tree_out.carry;
      end
    end
  end

  assign io_out_valid = fa_v;
  assign io_out_sum   = fa_q.sum;
  assign io_out_carry = fa_q.carry;
  assign io_out_res   = fa_res;
`else
  assign io_out_valid = vld[S-1];
  assign io_out_sum   = tree_out.sum;
  assign io_out_carry = tree_out.carry;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: directed checks of the CSA tree pipeline, plus a
// degenerate NUM_IN=3 / REG_EVERY=4 instance.
module tb_csa_tree_pipe;

  localparam int W  = 13;
  localparam int N  = 8;
  localparam int NW = W * N;
`ifdef CSA_TREE_FINAL_ADD_EN
  localparam int LAT  = 3;
  localparam int LAT3 = 2;
`else
  localparam int LAT  = 2;
  localparam int LAT3 = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          io_flush;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [NW-1:0] io_in_bits;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_out_sum;
  logic [W-1:0]  io_out_carry;
  logic [W-1:0]  io_out_res;

  logic          d3_flush;
  logic          d3_in_valid;
  logic          d3_in_ready;
  logic [3*W-1:0] d3_in_bits;
  logic          d3_out_valid;
  logic          d3_out_ready;
  logic [W-1:0]  d3_out_sum;
  logic [W-1:0]  d3_out_carry;
  logic [W-1:0]  d3_out_res;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  csa_tree_pipe #(.WIDTH(W), .NUM_IN(N), .REG_EVERY(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_flush    (io_flush),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_bits  (io_in_bits),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_sum  (io_out_sum),
`ifdef CSA_TREE_FINAL_ADD_EN
    .io_out_carry(io_out_carry),
    .io_out_res  (io_out_res)
`else
    .io_out_carry(io_out_carry)
`endif
  );

  csa_tree_pipe #(.WIDTH(W), .NUM_IN(3), .REG_EVERY(4)) dut3 (
    .clock       (clock),
    .reset       (reset),
    .io_flush    (d3_flush),
    .io_in_valid (d3_in_valid),
    .io_in_ready (d3_in_ready),
    .io_in_bits  (d3_in_bits),
    .io_out_valid(d3_out_valid),
    .io_out_ready(d3_out_ready),
    .io_out_sum  (d3_out_sum),
`ifdef CSA_TREE_FINAL_ADD_EN
    .io_out_carry(d3_out_carry),
    .io_out_res  (d3_out_res)
`else
    .io_out_carry(d3_out_carry)
`endif
  );

`ifndef CSA_TREE_FINAL_ADD_EN
  assign io_out_res = '0;
  assign d3_out_res = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [NW-1:0] splat(input logic [W-1:0] v);
    logic [NW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] ref_sum(input logic [NW-1:0] b);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + b[k*W +: W];
    return s;
  endfunction

  function automatic logic [W-1:0] out_total();
    logic [W-1:0] r;
    r = io_out_sum + io_out_carry;
    return r;
  endfunction

  task automatic push_and_time(input string tag, input logic [NW-1:0] bits,
                               input logic [W-1:0] exp);
    int lat;
    io_out_ready = 1'b1;
    io_in_bits   = bits;
    io_in_valid  = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(io_in_ready), 32'd1);
    tick();
    io_in_valid = 1'b0;
    lat = 1;
    while (!io_out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_val"}, 32'(out_total()), 32'(exp));
`ifdef CSA_TREE_FINAL_ADD_EN
    check({tag, "_res"}, 32'(io_out_res), 32'(exp));
`endif
    tick();
    tick();
  endtask

  task automatic push3(input string tag, input logic [3*W-1:0] bits,
                       input logic [W-1:0] exp);
    int lat;
    logic [W-1:0] r;
    d3_out_ready = 1'b1;
    d3_in_bits   = bits;
    d3_in_valid  = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(d3_in_ready), 32'd1);
    tick();
    d3_in_valid = 1'b0;
    lat = 1;
    while (!d3_out_valid && lat < 8) begin
      tick();
      lat++;
    end
    r = d3_out_sum + d3_out_carry;
    check({tag, "_lat"}, 32'(lat), 32'(LAT3));
    check({tag, "_val"}, 32'(r), 32'(exp));
`ifdef CSA_TREE_FINAL_ADD_EN
    check({tag, "_res"}, 32'(d3_out_res), 32'(exp));
`endif
    tick();
    tick();
  endtask

  task automatic fill(input string tag, input int n, input logic [W-1:0] v);
    int acc;
    int c;
    logic took;
    acc = 0;
    c = 0;
    io_out_ready = 1'b0;
    io_in_bits   = splat(v);
    while (acc < n && c < 10) begin
      io_in_valid = 1'b1;
      #1;
      took = io_in_ready;
      tick();
      if (took) acc++;
      c++;
    end
    io_in_valid = 1'b0;
    check({tag, "_fill"}, 32'(acc), 32'(n));
  endtask

  task automatic stream(input string tag, input int nb, input bit rnd,
                        output int last_acc);
    logic [W-1:0]  q[$];
    logic [NW-1:0] bits;
    logic [W-1:0]  r;
    int sent;
    int got;
    int cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    last_acc = -1;
    while ((sent < nb || got < nb) && cyc < 3000) begin
      for (int k = 0; k < N; k++) bits[k*W +: W] = W'($urandom);
      io_in_bits   = bits;
      io_in_valid  = (sent < nb) && (!rnd || ($urandom_range(0, 3) != 0));
      io_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (io_out_valid && io_out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_spur"}, 32'(io_out_valid), 32'd0);
        end else begin
          r = out_total();
          check({tag, "_data"}, 32'(r), 32'(q.pop_front()));
          got++;
        end
      end
      if (io_in_valid && io_in_ready) begin
        q.push_back(ref_sum(bits));
        sent++;
        if (sent == nb) last_acc = cyc;
      end
      tick();
      cyc++;
    end
    io_in_valid = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(nb));
  endtask

  initial begin
    logic [NW-1:0]  v;
    logic [3*W-1:0] v3;
    logic [W-1:0]   e;
    logic [W-1:0]   r;
    int acc;
    int cnt;
    int last;
    logic took;

    reset        = 1'b1;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_out_ready = 1'b0;
    d3_flush     = 1'b0;
    d3_in_valid  = 1'b0;
    d3_in_bits   = '0;
    d3_out_ready = 1'b0;

    #12;
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_sum", 32'(io_out_sum), 32'd0);
    check("rst_carry", 32'(io_out_carry), 32'd0);
    check("rst_ready", 32'(io_in_ready), 32'd1);
`ifdef CSA_TREE_FINAL_ADD_EN
    check("rst_res", 32'(io_out_res), 32'd0);
`endif
    io_flush = 1'b1;
    #1;
    check("rst_flush_ready", 32'(io_in_ready), 32'd0);
    io_flush = 1'b0;
    reset = 1'b0;
    tick();

    for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
    push_and_time("basic", v, W'(36));
    push_and_time("wrap", splat(13'h1FFF), 13'h1FF8);
    push_and_time("zero_wrap", splat(13'h1000), 13'h0000);
    for (int k = 0; k < N; k++) v[k*W +: W] = k[0] ? 13'h1555 : 13'h0AAA;
    push_and_time("alt", v, 13'h1FFC);

    io_out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      io_in_bits  = splat(W'((acc + 1) * 'h111));
      io_in_valid = 1'b1;
      #1;
      took = io_in_ready;
      tick();
      if (took) acc++;
    end
    io_in_valid = 1'b0;
    #1;
    check("bp_accepted", 32'(acc), 32'(LAT));
    check("bp_in_ready", 32'(io_in_ready), 32'd0);
    check("bp_out_valid", 32'(io_out_valid), 32'd1);
    check("bp_head", 32'(out_total()), 32'h888);
    tick();
    tick();
    check("bp_stall_valid", 32'(io_out_valid), 32'd1);
    check("bp_stall_head", 32'(out_total()), 32'h888);
    io_out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 32'(io_in_ready), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      e = W'(k * 'h888);
      check("bp_drain_valid", 32'(io_out_valid), 32'd1);
      check("bp_drain_val", 32'(out_total()), 32'(e));
      tick();
    end
    check("bp_drained", 32'(io_out_valid), 32'd0);
    tick();

    stream("rnd", 100, 1'b1, last);
    tick();
    tick();
    stream("thru", 20, 1'b0, last);
    check("thru_cycles", 32'(last + 1), 32'd20);
    tick();
    tick();

    fill("fl", 2, 13'h0005);
    io_in_bits  = splat(13'h0007);
    io_in_valid = 1'b1;
    io_flush    = 1'b1;
    #1;
    check("fl_ready_low", 32'(io_in_ready), 32'd0);
    tick();
    io_flush    = 1'b0;
    io_in_valid = 1'b0;
    #1;
    check("fl_out_valid", 32'(io_out_valid), 32'd0);
    check("fl_ready_back", 32'(io_in_ready), 32'd1);
    io_out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (io_out_valid) cnt++;
    end
    check("fl_no_ghost", 32'(cnt), 32'd0);
    push_and_time("fl_after", splat(13'h0003), W'(24));

    fill("rs", LAT, 13'h0009);
    #1;
    check("rs_pre_valid", 32'(io_out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async_valid", 32'(io_out_valid), 32'd0);
    check("rs_async_sum", 32'(io_out_sum), 32'd0);
    check("rs_async_carry", 32'(io_out_carry), 32'd0);
    #1;
    reset = 1'b0;
    io_out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (io_out_valid) cnt++;
    end
    check("rs_no_stale", 32'(cnt), 32'd0);
    push_and_time("rs_after", splat(13'h0002), W'(16));

    v3 = {13'd7, 13'd6, 13'd5};
    push3("n3_basic", v3, W'(18));
    v3 = {13'h0000, 13'h0001, 13'h1FFF};
    push3("n3_wrap", v3, W'(0));
    r = 13'h1234;
    v3 = {13'h0F0F, r, 13'h00FF};
    push3("n3_mix", v3, W'(13'h0F0F + 13'h1234 + 13'h00FF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
